// File: rtl/digest_checker.sv
// rtl/digest_checker.sv - compares a streamed digest byte-by-byte against a build-time constant
module digest_checker #(
    parameter int DIGEST_BYTES = 32,
    parameter int VALID_BIT    = 7,
    parameter logic [8*DIGEST_BYTES-1:0] EXPECTED =
        256'h508C5E8C327C14E2E1A72BA34EEB452F37458B209ED63A294D999B4C86675982,
    parameter int TIMEOUT_W    = 24,
    localparam int CNT_W       = $clog2(DIGEST_BYTES + 1),
    localparam int IDX_W       = $clog2(DIGEST_BYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start_i,
    input  logic [7:0]       uo_out_i,
    input  logic [7:0]       uio_out_i,
    input  logic [7:0]       uio_oe_i,
    output logic             busy_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic             overrun_o,
    output logic [CNT_W-1:0] byte_cnt_o,
    output logic [IDX_W-1:0] err_idx_o
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RECV, S_DONE} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     byte_cnt_q;
    logic [IDX_W-1:0]     err_idx_q;
    logic                 pass_q;
    logic                 fail_q;
    logic                 timeout_q;
    logic                 overrun_q;
    logic                 mis_q;
    logic [TIMEOUT_W-1:0] tmo_q;

    logic                 vld;
    logic [7:0]           exp_bytes [DIGEST_BYTES];
    logic [7:0]           exp_byte;
    logic                 byte_bad;
    logic                 last_byte;
    logic [TIMEOUT_W-1:0] tmo_inc;
    logic                 tmo_hit;
    logic                 unused_uio;

    assign vld        = uio_oe_i[VALID_BIT] & uio_out_i[VALID_BIT];
    assign unused_uio = ^{uio_out_i, uio_oe_i};

    // Byte 0 is the most significant byte of EXPECTED.
    for (genvar i = 0; i < DIGEST_BYTES; i++) begin : g_exp
        assign exp_bytes[i] = EXPECTED[8*(DIGEST_BYTES-i)-1 -: 8];
    end

    assign exp_byte  = exp_bytes[byte_cnt_q[IDX_W-1:0]];
    assign byte_bad  = (uo_out_i != exp_byte);
    assign last_byte = (byte_cnt_q == CNT_W'(DIGEST_BYTES - 1));
    assign tmo_inc   = tmo_q + 1'b1;
    assign tmo_hit   = &tmo_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            err_idx_q  <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
            mis_q      <= 1'b0;
            tmo_q      <= '0;
        end else if (ena) begin
            if (start_i) begin
                // Start beats a coincident byte, which is dropped.
                state_q    <= S_ARMED;
                byte_cnt_q <= '0;
                err_idx_q  <= '0;
                pass_q     <= 1'b0;
                fail_q     <= 1'b0;
                timeout_q  <= 1'b0;
                overrun_q  <= 1'b0;
                mis_q      <= 1'b0;
                tmo_q      <= '0;
            end else begin
                case (state_q)
                    S_ARMED, S_RECV: begin
                        if (vld) begin
                            tmo_q      <= '0;
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            if (byte_bad && !mis_q) begin
                                mis_q     <= 1'b1;
                                err_idx_q <= byte_cnt_q[IDX_W-1:0];
                            end
                            if (last_byte) begin
                                state_q <= S_DONE;
                                if (byte_bad || mis_q) fail_q <= 1'b1;
                                else                   pass_q <= 1'b1;
                            end else begin
                                state_q <= S_RECV;
                            end
                        end else begin
                            tmo_q <= tmo_inc;
                            if (tmo_hit) begin
                                timeout_q <= 1'b1;
                                fail_q    <= 1'b1;
                                state_q   <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        if (vld) begin
                            overrun_q <= 1'b1;
                            fail_q    <= 1'b1;
                            pass_q    <= 1'b0;
                            if (byte_cnt_q != CNT_W'(DIGEST_BYTES))
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o     = (state_q == S_ARMED) || (state_q == S_RECV);
    assign pass_o     = pass_q;
    assign fail_o     = fail_q;
    assign timeout_o  = timeout_q;
    assign overrun_o  = overrun_q;
    assign byte_cnt_o = byte_cnt_q;
    assign err_idx_o  = err_idx_q;

endmodule
